// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count and threshold/error flags
//
// Purpose: synchronous FIFO of DEPTH entries (any DEPTH >= 2, not only powers
// of two). Read data is registered and appears one cycle after an accepted read.
// Status flags are decoded from the registered occupancy count.
//
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN
//   defined   -> overflow/underflow are sticky registers, cleared only by rst
//   undefined -> overflow/underflow are tied to 0
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   data_wr      in   write data
//   wr_en        in   write request (ignored while full)
//   fifo_full    out  count == DEPTH
//   data_rd      out  registered read data, holds between accepted reads
//   rd_en        in   read request (ignored while empty)
//   fifo_empty   out  count == 0
//   fifo_count   out  current occupancy
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty

module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_wr,
    input  logic                       wr_en,
    output logic                       fifo_full,
    output logic [DATA_WIDTH-1:0]      data_rd,
    input  logic                       rd_en,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance uses the pre-edge flags, so a full FIFO rejects a write even
    // when a read frees a slot on the same edge (and symmetrically for empty).
    assign wr_ok = wr_en && !fifo_full;
    assign rd_ok = rd_en && !fifo_empty;

    // Flags are pure decodes of the registered count: no combinational path
    // from wr_en/rd_en, so they cannot glitch within a cycle.
    assign fifo_count   = count;
    assign fifo_full    = (count == CW'(DEPTH));
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // Explicit wrap at DEPTH-1 keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data_rd <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr  <= ptr_next(rd_ptr);
                data_rd <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count return to zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= data_wr;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && fifo_full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags against a queue model

module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default-parameter instance (DEPTH=16, AF=14, AE=2)
    logic       rst = 1'b1;
    logic [7:0] data_wr = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
    logic [7:0] data_rd;
    logic [4:0] fifo_count;

    sync_fifo_flags dut (
        .clk(clk), .rst(rst), .data_wr(data_wr), .wr_en(wr_en),
        .fifo_full(fifo_full), .data_rd(data_rd), .rd_en(rd_en),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    // Non-power-of-two instance (DEPTH=12)
    logic       rst_b = 1'b1;
    logic [7:0] data_wr_b = '0;
    logic       wr_en_b = 1'b0;
    logic       rd_en_b = 1'b0;
    logic       fifo_full_b, fifo_empty_b, almost_full_b, almost_empty_b, overflow_b, underflow_b;
    logic [7:0] data_rd_b;
    logic [3:0] fifo_count_b;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(12), .AF_THRESH(10), .AE_THRESH(2)) dut12 (
        .clk(clk), .rst(rst_b), .data_wr(data_wr_b), .wr_en(wr_en_b),
        .fifo_full(fifo_full_b), .data_rd(data_rd_b), .rd_en(rd_en_b),
        .fifo_empty(fifo_empty_b), .fifo_count(fifo_count_b),
        .almost_full(almost_full_b), .almost_empty(almost_empty_b),
        .overflow(overflow_b), .underflow(underflow_b)
    );

    // Reference model for the default instance
    logic [7:0] q[$];
    logic [7:0] m_rd  = '0;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock on the default instance; model applies the rules to pre-edge state.
    task automatic step(input bit rs, input bit w, input bit r, input logic [7:0] d);
        bit full;
        bit empty;
        full  = (q.size() == 16);
        empty = (q.size() == 0);
        rst = rs; wr_en = w; rd_en = r; data_wr = d;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && !empty) m_rd = q.pop_front();
            if (w && !full)  q.push_back(d);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (w && full)  m_ovf = 1'b1;
            if (r && empty) m_udf = 1'b1;
`endif
        end
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic check16(input string tag);
        chk({tag, ".count"}, 32'(fifo_count),   32'(q.size()));
        chk({tag, ".full"},  32'(fifo_full),    32'(q.size() == 16));
        chk({tag, ".empty"}, 32'(fifo_empty),   32'(q.size() == 0));
        chk({tag, ".af"},    32'(almost_full),  32'(q.size() >= 14));
        chk({tag, ".ae"},    32'(almost_empty), 32'(q.size() <= 2));
        chk({tag, ".rd"},    32'(data_rd),      32'(m_rd));
        chk({tag, ".ovf"},   32'(overflow),     32'(m_ovf));
        chk({tag, ".udf"},   32'(underflow),    32'(m_udf));
    endtask

    initial begin
        int nxt_wr;
        int nxt_rd;
        int cnt12;
        bit w;
        bit r;

        // Reset state
        step(1, 0, 0, 8'h00);
        check16("reset");

        // Fill with 0x00..0x0F; almost_full rises after the 14th write
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 8'(i));
            check16($sformatf("fill%0d", i));
        end
        chk("fill.af_const", 32'(almost_full), 32'd1);

        // Write while full: dropped
        step(0, 1, 0, 8'hAA);
        check16("ovf_wr");

        // Drain 16, expecting 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 8'h00);
            check16($sformatf("drain%0d", i));
            chk($sformatf("drain%0d.val", i), 32'(data_rd), 32'(i));
        end

        // Read on empty after reset, flag sticks
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        check16("udf_rd");
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check16("udf_hold");

        // Simultaneous read/write at count 5
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h10 + i));
        step(0, 1, 1, 8'h20);
        check16("rw_at5");
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 8'h00);
            check16($sformatf("rw5_drain%0d", i));
        end
        // Simultaneous at empty: write accepted, data_rd unchanged
        step(0, 1, 1, 8'h33);
        check16("rw_empty");
        // Fill up to full, then simultaneous read/write
        for (int i = 0; i < 15; i++) step(0, 1, 0, 8'(8'h40 + i));
        check16("refill");
        step(0, 1, 1, 8'hEE);
        check16("rw_full");
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 1, 8'h00);
            check16($sformatf("rwf_drain%0d", i));
        end

        // Reset mid-operation with wr_en asserted
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 8'(8'h70 + i));
        step(1, 1, 0, 8'h99);
        check16("mid_rst");
        step(0, 1, 0, 8'h5C);
        step(0, 0, 1, 8'h00);
        check16("post_rst");
        chk("post_rst.val", 32'(data_rd), 32'h5C);

        // Random traffic on the default instance
        for (int i = 0; i < 400; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            check16($sformatf("rnd%0d", i));
        end

        // DEPTH=12: 40 incrementing writes, random interleaving, order across wraps
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        chk("d12.reset_empty", 32'(fifo_empty_b), 32'd1);
        nxt_wr = 0;
        nxt_rd = 0;
        cnt12  = 0;
        for (int c = 0; c < 2000 && nxt_rd < 40; c++) begin
            w = (nxt_wr < 40) && ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 5);
            wr_en_b = w; rd_en_b = r; data_wr_b = 8'(nxt_wr);
            begin
                bit acc_w;
                bit acc_r;
                acc_w = w && (cnt12 < 12);
                acc_r = r && (cnt12 > 0);
                @(posedge clk);
                #1;
                wr_en_b = 1'b0; rd_en_b = 1'b0;
                if (acc_r) begin
                    chk($sformatf("d12.rd%0d", nxt_rd), 32'(data_rd_b), 32'(nxt_rd));
                    nxt_rd++;
                end
                if (acc_w) nxt_wr++;
                cnt12 = cnt12 + int'(acc_w) - int'(acc_r);
                chk($sformatf("d12.count%0d", c), 32'(fifo_count_b), 32'(cnt12));
                chk($sformatf("d12.full%0d", c), 32'(fifo_full_b), 32'(cnt12 == 12));
            end
        end
        chk("d12.all_read", 32'(nxt_rd), 32'd40);
        chk("d12.end_empty", 32'(fifo_empty_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
